// File: rtl/doom58_vga_pkg.sv
// Shared screen geometry, colour constants and arbiter FSM state type
// for the VGA write path.
package doom58_vga_pkg;
  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;
  localparam int X_W      = 8;
  localparam int Y_W      = 7;
  localparam int COLOUR_W = 3;

  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_DONE
  } arb_state_t;
endpackage

// File: rtl/vga_clear_sweep.sv
// Raster sweep counters for the full-screen clear: x inner, y outer,
// with an optional idle gap after each row.
module vga_clear_sweep
  import doom58_vga_pkg::*;
#(
  parameter int CLEAR_ROW_GAP = 0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           run,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic           active,
  output logic           last
);
  localparam int GAP_W = (CLEAR_ROW_GAP > 0) ? $clog2(CLEAR_ROW_GAP + 1) : 1;

  logic [GAP_W-1:0] gap;

  assign active = (gap == '0);
  assign last   = active && (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clock) begin
    if (reset || start) begin
      x   <= '0;
      y   <= '0;
      gap <= '0;
    end else if (run) begin
      if (!active) begin
        gap <= gap - 1'b1;
      end else if (x == X_LAST) begin
        // Hold y at the final row so the counters never leave the screen.
        x <= '0;
        if (!last) begin
          y   <= y + 1'b1;
          gap <= GAP_W'(CLEAR_ROW_GAP);
        end
      end else begin
        x <= x + 1'b1;
      end
    end
  end
endmodule

// File: rtl/vga_write_arbiter.sv
// Round-robin arbiter for the VGA adapter pixel-write port with a built-in
// full-screen clear. Optional macro VGA_ARB_CLIP_EN drops off-screen pixels.
module vga_write_arbiter
  import doom58_vga_pkg::*;
#(
  parameter int NUM_REQ       = 3,
  parameter int CLEAR_ROW_GAP = 0
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         clear_start,
  input  logic [COLOUR_W-1:0]          clear_colour,
  output logic                         clear_busy,
  output logic                         clear_done,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*X_W-1:0]       req_x,
  input  logic [NUM_REQ*Y_W-1:0]       req_y,
  input  logic [NUM_REQ*COLOUR_W-1:0]  req_colour,
  output logic [NUM_REQ-1:0]           grant,
  output logic [X_W-1:0]               vga_x,
  output logic [Y_W-1:0]               vga_y,
  output logic [COLOUR_W-1:0]          vga_colour,
  output logic                         vga_write
);
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  arb_state_t state, state_next;

  logic [PTR_W-1:0]    ptr, gnt_idx;
  logic                gnt_vld, arb_en, clear_accept, pix_ok;
  logic [COLOUR_W-1:0] clr_colour;
  logic [X_W-1:0]      sweep_x, pix_x;
  logic [Y_W-1:0]      sweep_y, pix_y;
  logic [COLOUR_W-1:0] pix_colour;
  logic                sweep_active, sweep_last;

  // A clear request in IDLE takes the port ahead of any pending pixel.
  assign clear_accept = !reset && (state == ST_IDLE) && clear_start;
  assign arb_en       = !reset && (state == ST_IDLE) && !clear_start;
  assign clear_busy   = !reset && (state != ST_IDLE);
  assign clear_done   = !reset && (state == ST_DONE);

  vga_clear_sweep #(.CLEAR_ROW_GAP(CLEAR_ROW_GAP)) u_sweep (
    .clock  (clock),
    .reset  (reset),
    .start  (clear_accept),
    .run    (state == ST_CLEAR),
    .x      (sweep_x),
    .y      (sweep_y),
    .active (sweep_active),
    .last   (sweep_last)
  );

  always_comb begin
    int idx;
    idx     = 0;
    gnt_vld = 1'b0;
    gnt_idx = '0;
    grant   = '0;
    if (arb_en) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!gnt_vld && req[idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = PTR_W'(idx);
        end
      end
    end
    if (gnt_vld) grant[gnt_idx] = 1'b1;
  end

  assign pix_x      = req_x[X_W*gnt_idx +: X_W];
  assign pix_y      = req_y[Y_W*gnt_idx +: Y_W];
  assign pix_colour = req_colour[COLOUR_W*gnt_idx +: COLOUR_W];

`ifdef VGA_ARB_CLIP_EN
  assign pix_ok = (pix_x < X_W'(SCREEN_W)) && (pix_y < Y_W'(SCREEN_H));
`else
  assign pix_ok = 1'b1;
`endif

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:  if (clear_start) state_next = ST_CLEAR;
      ST_CLEAR: if (sweep_last) state_next = ST_DONE;
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      ptr        <= '0;
      clr_colour <= BLACK;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= '0;
      vga_write  <= 1'b0;
    end else begin
      state     <= state_next;
      vga_write <= 1'b0;
      if (clear_accept) clr_colour <= clear_colour;
      if (gnt_vld) begin
        ptr        <= (gnt_idx == PTR_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        vga_x      <= pix_x;
        vga_y      <= pix_y;
        vga_colour <= pix_colour;
        vga_write  <= pix_ok;
      end else if ((state == ST_CLEAR) && sweep_active) begin
        vga_x      <= sweep_x;
        vga_y      <= sweep_y;
        vga_colour <= clr_colour;
        vga_write  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_vga_write_arbiter.sv
// Directed bench for vga_write_arbiter: expected pixels are queued when
// stimulus is applied and compared as the adapter strobes appear.
module tb_vga_write_arbiter;
  import doom58_vga_pkg::*;

  localparam int N = 3;

  logic             clock = 1'b0;
  logic             reset;
  logic             clear_start;
  logic [2:0]       clear_colour;
  logic             clear_busy, clear_done;
  logic [N-1:0]     req;
  logic [N*8-1:0]   req_x;
  logic [N*7-1:0]   req_y;
  logic [N*3-1:0]   req_colour;
  logic [N-1:0]     grant;
  logic [7:0]       vga_x;
  logic [6:0]       vga_y;
  logic [2:0]       vga_colour;
  logic             vga_write;

  int checks = 0;
  int errors = 0;
  logic [17:0] exp_q[$];

  vga_write_arbiter #(.NUM_REQ(N), .CLEAR_ROW_GAP(0)) dut (
    .clock        (clock),
    .reset        (reset),
    .clear_start  (clear_start),
    .clear_colour (clear_colour),
    .clear_busy   (clear_busy),
    .clear_done   (clear_done),
    .req          (req),
    .req_x        (req_x),
    .req_y        (req_y),
    .req_colour   (req_colour),
    .grant        (grant),
    .vga_x        (vga_x),
    .vga_y        (vga_y),
    .vga_colour   (vga_colour),
    .vga_write    (vga_write)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_pix(input int ch, input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
    req_x[8*ch +: 8]      = x;
    req_y[7*ch +: 7]      = y;
    req_colour[3*ch +: 3] = c;
  endtask

  task automatic push_sweep(input int count, input logic [2:0] c);
    for (int i = 0; i < count; i++)
      exp_q.push_back({8'(i % 160), 7'(i / 160), c});
  endtask

  // Called at posedge+1; leaves reset low at posedge+1.
  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
  endtask

  always @(negedge clock) begin
    if (vga_write === 1'b1) begin
      if (exp_q.size() == 0) chk("unexpected_write", 32'd1, 32'd0);
      else chk("pixel", {14'b0, vga_x, vga_y, vga_colour}, {14'b0, exp_q.pop_front()});
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, done_cnt, bad_grant;
    reset        = 1'b1;
    clear_start  = 1'b0;
    clear_colour = 3'b000;
    req          = 3'b001;
    req_x        = '0;
    req_y        = '0;
    req_colour   = '0;
    set_pix(0, 8'd10, 7'd20, 3'b100);

    // Reset state with a request already pending
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_write", 32'(vga_write), 32'd0);
    chk("rst_xyc", {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
    chk("rst_busy", 32'(clear_busy), 32'd0);
    chk("rst_done", 32'(clear_done), 32'd0);

    // Single request, one-cycle latency
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("single_grant", 32'(grant), 32'b001);
    exp_q.push_back({8'd10, 7'd20, 3'b100});
    @(posedge clock); #1 req = 3'b000;
    @(negedge clock);
    chk("single_write", 32'(vga_write), 32'd1);
    chk("idle_grant", 32'(grant), 32'd0);
    @(posedge clock); #1;

    // Round robin over all three channels
    do_reset();
    set_pix(0, 8'd1, 7'd2, 3'b001);
    set_pix(1, 8'd4, 7'd3, 3'b010);
    set_pix(2, 8'd7, 7'd4, 3'b011);
    req = 3'b111;
    for (int k = 0; k < 6; k++) begin
      @(negedge clock);
      chk("rr_grant", 32'(grant), 32'(1 << (k % 3)));
      case (k % 3)
        0: exp_q.push_back({8'd1, 7'd2, 3'b001});
        1: exp_q.push_back({8'd4, 7'd3, 3'b010});
        default: exp_q.push_back({8'd7, 7'd4, 3'b011});
      endcase
      @(posedge clock); #1;
    end
    req = 3'b000;
    @(negedge clock);
    chk("rr_last_write", 32'(vga_write), 32'd1);
    @(posedge clock); #1;

    // Full clear with requests pending
    req          = 3'b011;
    clear_start  = 1'b1;
    clear_colour = 3'b010;
    @(negedge clock);
    chk("start_grant", 32'(grant), 32'd0);
    push_sweep(19200, 3'b010);
    @(posedge clock); #1;
    clear_start  = 1'b0;
    clear_colour = 3'b101;
    n = 0; done_cnt = 0; bad_grant = 0;
    while (done_cnt == 0 && n < 19300) begin
      @(negedge clock);
      n++;
      if (n == 1) chk("clear_busy", 32'(clear_busy), 32'd1);
      if (grant !== 3'b000) bad_grant++;
      if (clear_done === 1'b1) done_cnt++;
      clear_start = (n == 100);
    end
    clear_start = 1'b0;
    chk("clear_cycles", 32'(n), 32'd19201);
    chk("clear_grants", 32'(bad_grant), 32'd0);
    chk("clear_done_seen", 32'(done_cnt), 32'd1);
    chk("done_busy", 32'(clear_busy), 32'd1);
    @(negedge clock);
    chk("post_grant", 32'(grant), 32'b001);
    chk("post_done", 32'(clear_done), 32'd0);
    chk("post_busy", 32'(clear_busy), 32'd0);
    exp_q.push_back({8'd1, 7'd2, 3'b001});
    @(posedge clock); #1 req = 3'b000;
    repeat (2) @(posedge clock); #1;
    chk("clear_queue_empty", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a clear, then restart from (0,0)
    clear_start  = 1'b1;
    clear_colour = 3'b110;
    push_sweep(500, 3'b110);
    @(posedge clock); #1 clear_start = 1'b0;
    repeat (500) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    chk("abort_busy_rst", 32'(clear_busy), 32'd0);
    chk("abort_write_rst", 32'(vga_write), 32'd0);
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("abort_busy", 32'(clear_busy), 32'd0);
    chk("abort_write", 32'(vga_write), 32'd0);
    chk("abort_xyc", {14'b0, vga_x, vga_y, vga_colour}, 32'd0);
    chk("abort_queue_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clock); #1;
    clear_start  = 1'b1;
    clear_colour = 3'b001;
    push_sweep(3, 3'b001);
    @(posedge clock); #1 clear_start = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock);
    chk("restart_write_off", 32'(vga_write), 32'd0);
    @(posedge clock); #1;
    chk("restart_queue_empty", 32'(exp_q.size()), 32'd0);

    // Off-screen pixel handling
    do_reset();
    set_pix(0, 8'd160, 7'd5, 3'b011);
    req = 3'b001;
    @(negedge clock);
    chk("clip_grant", 32'(grant), 32'b001);
`ifndef VGA_ARB_CLIP_EN
    exp_q.push_back({8'd160, 7'd5, 3'b011});
`endif
    @(posedge clock); #1 req = 3'b000;
    repeat (2) @(posedge clock); #1;
    chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
